dds_pulse_sequencer: RTL and testbench

- Parametrised successor to the single-waveform DDS modulator core.
- Generates a pulsed radar burst as an AXI4-Stream of DDS Compiler phase-config words (PINC/POFF/RESYNC).
- Supports CW, LFM chirp and binary-phase-coded pulses, with programmable pulse length, PRI and pulse count.
- Sits between the AXI4-Lite register bank (config inputs) and the DDS Compiler config slave.

---
 rtl/dds_pulse_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_dds_pulse_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// dds_pulse_sequencer: pulsed CW / LFM / phase-coded burst generator emitting
// DDS Compiler phase-config beats. Optional macro: DDS_MOD_PHASE_CODE_EN.
// Revision: 1.0
// ============================================================================
module dds_pulse_sequencer #(
  parameter int PHASE_W      = 32,
  parameter int CNT_W        = 32,
  parameter int CODE_LEN_MAX = 16,
  parameter int TDATA_W      = 8*((2*PHASE_W+8)/8)
) (
  input  logic                              S_AXI_CLK,
  input  logic                              S_AXI_ARESETN,
  input  logic                              start_i,
  input  logic                              stop_i,
  input  logic [1:0]                        mode_i,
  input  logic [PHASE_W-1:0]                pinc_start_i,
  input  logic [PHASE_W-1:0]                pinc_step_i,
  input  logic [CNT_W-1:0]                  pulse_len_i,
  input  logic [CNT_W-1:0]                  pri_i,
  input  logic [CNT_W-1:0]                  num_pulses_i,
  input  logic [CODE_LEN_MAX-1:0]           code_i,
  input  logic [$clog2(CODE_LEN_MAX+1)-1:0] code_len_i,
  input  logic [CNT_W-1:0]                  chip_len_i,
  output logic                              busy_o,
  output logic [CNT_W-1:0]                  pulse_cnt_o,
  output logic                              cfg_err_o,
  output logic                              overrun_o,
  output logic                              dds_en_o,
  output logic [TDATA_W-1:0]                m_axis_modulation_tdata,
  output logic                              m_axis_modulation_tvalid,
  output logic                              m_axis_modulation_tlast,
  input  logic                              m_axis_modulation_tready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               launch_q, launch_d;
  logic               busy_q, busy_d;
  logic               cfg_err_q, cfg_err_d;
  logic               overrun_q, overrun_d;
  logic               stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0]   samp_q, samp_d;
  logic [CNT_W-1:0]   pri_cnt_q, pri_cnt_d;
  logic [PHASE_W-1:0] pinc_q, pinc_d;
  logic               lfm_q, lfm_d;
  logic [PHASE_W-1:0] pinc_start_q, pinc_start_d;
  logic [PHASE_W-1:0] pinc_step_q, pinc_step_d;
  logic [CNT_W-1:0]   pulse_len_q, pulse_len_d;
  logic [CNT_W-1:0]   pri_q, pri_d;
  logic [CNT_W-1:0]   num_pulses_q, num_pulses_d;

  logic               tvalid, hs, nat_last, stop_any, last_pulse, pri_due;
  logic               code_bad, start_ok, enter_pulse;
  logic [CNT_W-1:0]   pri_cnt_inc;
  logic [PHASE_W-1:0] poff;

`ifdef DDS_MOD_PHASE_CODE_EN
  localparam int CL_W  = $clog2(CODE_LEN_MAX+1);
  localparam int IDX_W = (CODE_LEN_MAX > 1) ? $clog2(CODE_LEN_MAX) : 1;

  logic                    code_mode_q, code_mode_d;
  logic [CODE_LEN_MAX-1:0] code_q, code_d;
  logic [CL_W-1:0]         code_len_q, code_len_d;
  logic [CNT_W-1:0]        chip_len_q, chip_len_d;
  logic [CNT_W-1:0]        chip_cnt_q, chip_cnt_d;
  logic [IDX_W-1:0]        chip_idx_q, chip_idx_d;

  assign code_bad = (mode_i == 2'd2) &&
                    ((code_len_i == '0) || (chip_len_i == '0) ||
                     (code_len_i > CL_W'(CODE_LEN_MAX)));
  assign poff     = (code_mode_q && code_q[chip_idx_q]) ?
                    {1'b1, {(PHASE_W-1){1'b0}}} : '0;
`else
  logic unused_code;
  assign unused_code = ^{code_i, code_len_i, chip_len_i};
  assign code_bad    = 1'b0;
  assign poff        = '0;
`endif

  assign tvalid      = (state_q == PULSE);
  assign hs          = tvalid & m_axis_modulation_tready;
  assign nat_last    = (samp_q == pulse_len_q - CNT_W'(1));
  assign stop_any    = stop_i | stop_pend_q;
  assign last_pulse  = (num_pulses_q != '0) && (pulse_cnt_q + CNT_W'(1) == num_pulses_q);
  assign pri_due     = (pri_cnt_q >= pri_q - CNT_W'(1));
  assign pri_cnt_inc = (pri_cnt_q == '1) ? pri_cnt_q : pri_cnt_q + CNT_W'(1);
  assign start_ok    = (pulse_len_i != '0) && (pri_i != '0) && !code_bad;

  always_comb begin
    state_d      = state_q;
    launch_d     = launch_q;
    busy_d       = busy_q;
    cfg_err_d    = 1'b0;
    overrun_d    = overrun_q;
    stop_pend_d  = stop_pend_q;
    pulse_cnt_d  = pulse_cnt_q;
    samp_d       = samp_q;
    pri_cnt_d    = pri_cnt_q;
    pinc_d       = pinc_q;
    lfm_d        = lfm_q;
    pinc_start_d = pinc_start_q;
    pinc_step_d  = pinc_step_q;
    pulse_len_d  = pulse_len_q;
    pri_d        = pri_q;
    num_pulses_d = num_pulses_q;
    enter_pulse  = 1'b0;
`ifdef DDS_MOD_PHASE_CODE_EN
    code_mode_d  = code_mode_q;
    code_d       = code_q;
    code_len_d   = code_len_q;
    chip_len_d   = chip_len_q;
    chip_cnt_d   = chip_cnt_q;
    chip_idx_d   = chip_idx_q;
`endif

    case (state_q)
      IDLE: begin
        // launch_q adds the extra cycle between an accepted start and the first beat
        if (launch_q) begin
          state_d     = PULSE;
          launch_d    = 1'b0;
          busy_d      = 1'b1;
          enter_pulse = 1'b1;
        end else if (start_i) begin
          if (start_ok) begin
            launch_d     = 1'b1;
            pulse_cnt_d  = '0;
            overrun_d    = 1'b0;
            lfm_d        = (mode_i == 2'd1);
            pinc_start_d = pinc_start_i;
            pinc_step_d  = pinc_step_i;
            pulse_len_d  = pulse_len_i;
            pri_d        = pri_i;
            num_pulses_d = num_pulses_i;
`ifdef DDS_MOD_PHASE_CODE_EN
            code_mode_d  = (mode_i == 2'd2);
            code_d       = code_i;
            code_len_d   = code_len_i;
            chip_len_d   = chip_len_i;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      PULSE: begin
        pri_cnt_d = pri_cnt_inc;
        if (hs) begin
          samp_d = samp_q + CNT_W'(1);
          if (lfm_q) pinc_d = pinc_q + pinc_step_q;
`ifdef DDS_MOD_PHASE_CODE_EN
          if (chip_cnt_q == chip_len_q - CNT_W'(1)) begin
            chip_cnt_d = '0;
            chip_idx_d = (CL_W'(chip_idx_q) == code_len_q - CL_W'(1)) ? '0 : chip_idx_q + IDX_W'(1);
          end else begin
            chip_cnt_d = chip_cnt_q + CNT_W'(1);
          end
`endif
          if (nat_last) begin
            pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
            if (pri_cnt_q >= pri_q) overrun_d = 1'b1;
          end
          if (stop_any || (nat_last && last_pulse)) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            stop_pend_d = 1'b0;
          end else if (nat_last) begin
            if (pri_due) enter_pulse = 1'b1;
            else         state_d     = GAP;
          end
        end else if (stop_i) begin
          stop_pend_d = 1'b1;
        end
      end
      GAP: begin
        pri_cnt_d = pri_cnt_inc;
        if (stop_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (pri_due) begin
          state_d     = PULSE;
          enter_pulse = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_pulse) begin
      samp_d    = '0;
      pinc_d    = pinc_start_q;
      pri_cnt_d = '0;
`ifdef DDS_MOD_PHASE_CODE_EN
      chip_cnt_d = '0;
      chip_idx_d = '0;
`endif
    end
  end

  always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= IDLE;
      launch_q     <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      stop_pend_q  <= 1'b0;
      pulse_cnt_q  <= '0;
      samp_q       <= '0;
      pri_cnt_q    <= '0;
      pinc_q       <= '0;
      lfm_q        <= 1'b0;
      pinc_start_q <= '0;
      pinc_step_q  <= '0;
      pulse_len_q  <= '0;
      pri_q        <= '0;
      num_pulses_q <= '0;
`ifdef DDS_MOD_PHASE_CODE_EN
      code_mode_q  <= 1'b0;
      code_q       <= '0;
      code_len_q   <= '0;
      chip_len_q   <= '0;
      chip_cnt_q   <= '0;
      chip_idx_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      launch_q     <= launch_d;
      busy_q       <= busy_d;
      cfg_err_q    <= cfg_err_d;
      overrun_q    <= overrun_d;
      stop_pend_q  <= stop_pend_d;
      pulse_cnt_q  <= pulse_cnt_d;
      samp_q       <= samp_d;
      pri_cnt_q    <= pri_cnt_d;
      pinc_q       <= pinc_d;
      lfm_q        <= lfm_d;
      pinc_start_q <= pinc_start_d;
      pinc_step_q  <= pinc_step_d;
      pulse_len_q  <= pulse_len_d;
      pri_q        <= pri_d;
      num_pulses_q <= num_pulses_d;
`ifdef DDS_MOD_PHASE_CODE_EN
      code_mode_q  <= code_mode_d;
      code_q       <= code_d;
      code_len_q   <= code_len_d;
      chip_len_q   <= chip_len_d;
      chip_cnt_q   <= chip_cnt_d;
      chip_idx_q   <= chip_idx_d;
`endif
    end
  end

  // Beat fields are zeroed outside PULSE so the bus idles at all-zero
  always_comb begin
    m_axis_modulation_tdata = '0;
    if (tvalid) begin
      m_axis_modulation_tdata[PHASE_W-1:0]         = pinc_q;
      m_axis_modulation_tdata[2*PHASE_W-1:PHASE_W] = poff;
      m_axis_modulation_tdata[2*PHASE_W]           = (samp_q == '0);
    end
  end

  assign m_axis_modulation_tvalid = tvalid;
  assign m_axis_modulation_tlast  = tvalid & (nat_last | stop_any);
  assign busy_o      = busy_q;
  assign dds_en_o    = busy_q;
  assign pulse_cnt_o = pulse_cnt_q;
  assign cfg_err_o   = cfg_err_q;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_pulse_sequencer.sv
`default_nettype none
// Randomised and directed bench for dds_pulse_sequencer against a sample-index
// reference model (PINC = start + n*step, POFF from code[(n/chip_len)%code_len]).
module tb_dds_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0;
  logic [1:0]  mode_i = '0;
  logic [31:0] pinc_start_i = '0, pinc_step_i = '0;
  logic [31:0] pulse_len_i = '0, pri_i = '0, num_pulses_i = '0, chip_len_i = '0;
  logic [15:0] code_i = '0;
  logic [4:0]  code_len_i = '0;
  logic        busy_o, cfg_err_o, overrun_o, dds_en_o;
  logic [31:0] pulse_cnt_o;
  logic [71:0] tdata;
  logic        tvalid, tlast;
  logic        tready = 1'b1;

  dds_pulse_sequencer dut (
    .S_AXI_CLK(clk), .S_AXI_ARESETN(rst_n),
    .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
    .pinc_start_i(pinc_start_i), .pinc_step_i(pinc_step_i),
    .pulse_len_i(pulse_len_i), .pri_i(pri_i), .num_pulses_i(num_pulses_i),
    .code_i(code_i), .code_len_i(code_len_i), .chip_len_i(chip_len_i),
    .busy_o(busy_o), .pulse_cnt_o(pulse_cnt_o), .cfg_err_o(cfg_err_o),
    .overrun_o(overrun_o), .dds_en_o(dds_en_o),
    .m_axis_modulation_tdata(tdata), .m_axis_modulation_tvalid(tvalid),
    .m_axis_modulation_tlast(tlast), .m_axis_modulation_tready(tready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]  m_mode;
  logic [31:0] m_ps, m_st;
  logic [15:0] m_code;
  int m_len, m_pri, m_num, m_clen, m_chlen, t_start;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] model_beat(input int n);
    logic [31:0] pinc, poff;
    pinc = (m_mode == 2'd1) ? m_ps + m_st * 32'(n) : m_ps;
    poff = '0;
`ifdef DDS_MOD_PHASE_CODE_EN
    if (m_mode == 2'd2 && m_code[(n / m_chlen) % m_clen]) poff = 32'h8000_0000;
`endif
    return {7'b0, (n == 0), poff, pinc};
  endfunction

  // Presents a start at a negedge, returns at the following negedge with inputs scrambled.
  task automatic start_cfg(input logic [1:0] mode, input logic [31:0] ps, input logic [31:0] st,
                           input int len, input int pri, input int num,
                           input logic [15:0] code, input int clen, input int chlen);
    @(negedge clk);
    m_mode = mode; m_ps = ps; m_st = st; m_len = len; m_pri = pri; m_num = num;
    m_code = code; m_clen = clen; m_chlen = chlen;
    mode_i = mode; pinc_start_i = ps; pinc_step_i = st; pulse_len_i = 32'(len);
    pri_i = 32'(pri); num_pulses_i = 32'(num); code_i = code;
    code_len_i = 5'(clen); chip_len_i = 32'(chlen);
    start_i = 1'b1; t_start = cyc;
    @(negedge clk);
    start_i = 1'b0;
    mode_i = 2'($urandom); pinc_start_i = $urandom; pinc_step_i = $urandom;
    pulse_len_i = $urandom_range(1, 20); pri_i = $urandom_range(1, 30);
    num_pulses_i = $urandom_range(0, 5); code_i = 16'($urandom);
  endtask

  task automatic run_burst(input logic [1:0] mode, input logic [31:0] ps, input logic [31:0] st,
                           input int len, input int pri, input int num,
                           input logic [15:0] code, input int clen, input int chlen, input int trm);
    int p, n, exp_start, budget;
    bit seen, ovr, done;
    start_cfg(mode, ps, st, len, pri, num, code, clen, chlen);
    check("cfg_err_on_accept", cfg_err_o, 0);
    exp_start = t_start + 2; p = 0; n = 0; seen = 0; ovr = 0; done = 0; budget = 0;
    @(negedge clk);
    while (!done && budget < 4000) begin
      case (trm)
        0: tready = 1'b1;
        1: tready = ((cyc % 2) == 0);
        default: tready = ($urandom_range(0, 3) != 0);
      endcase
      if (tvalid) begin
        if (!seen) begin
          check("pulse_start_cycle", 72'(cyc), 72'(exp_start));
          check("busy_in_pulse", busy_o, 1);
          seen = 1;
        end
        check("tdata", tdata, model_beat(n));
        check("tlast", tlast, (n == m_len - 1));
        if (tready) begin
          if (n == m_len - 1) begin
            if (cyc - exp_start >= m_pri) ovr = 1;
            exp_start = (exp_start + m_pri > cyc + 1) ? exp_start + m_pri : cyc + 1;
            p++; n = 0; seen = 0;
            if (m_num != 0 && p == m_num) done = 1;
          end else begin
            n++;
          end
        end
      end
      @(negedge clk);
      budget++;
    end
    check("burst_completed", done, 1);
    check("busy_after_burst", busy_o, 0);
    check("dds_en_after_burst", dds_en_o, 0);
    check("tvalid_after_burst", tvalid, 0);
    check("pulse_cnt", pulse_cnt_o, 72'(m_num));
    check("overrun", overrun_o, ovr);
    tready = 1'b1;
  endtask

  task automatic reject(input int len, input int pri, input logic [1:0] mode, input int clen, input int chlen);
    start_cfg(mode, 32'h10, 32'h0, len, pri, 1, 16'h5, clen, chlen);
    check("cfg_err_pulse", cfg_err_o, 1);
    check("busy_on_reject", busy_o, 0);
    @(negedge clk);
    check("cfg_err_one_cycle", cfg_err_o, 0);
    check("tvalid_on_reject", tvalid, 0);
    check("busy_after_reject", busy_o, 0);
  endtask

  task automatic wait_valid(input bit level, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (tvalid == level) begin ok = 1; break; end
      @(negedge clk);
    end
    check(tag, ok, 1);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy_o, 0);
    check("rst_dds_en", dds_en_o, 0);
    check("rst_pulse_cnt", pulse_cnt_o, 0);
    check("rst_cfg_err", cfg_err_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    rst_n = 1'b1;

    run_burst(2'd0, 32'h0100_0000, 32'h0, 4, 10, 2, 16'h0, 1, 1, 0);
    run_burst(2'd0, 32'h0200_0000, 32'h0, 4, 5, 2, 16'h0, 1, 1, 1);
    run_burst(2'd1, 32'hFFFF_FFF0, 32'h8, 4, 6, 1, 16'h0, 1, 1, 0);
    run_burst(2'd2, 32'h0400_0000, 32'h0, 8, 12, 1, 16'b101, 3, 2, 0);
    run_burst(2'd3, 32'h0300_0000, 32'h5, 3, 3, 2, 16'h0, 1, 1, 0);

    reject(0, 10, 2'd0, 1, 1);
    reject(4, 0, 2'd1, 1, 1);
`ifdef DDS_MOD_PHASE_CODE_EN
    reject(4, 10, 2'd2, 0, 2);
    reject(4, 10, 2'd2, 17, 2);
    reject(4, 10, 2'd2, 3, 0);
`else
    run_burst(2'd2, 32'h0500_0000, 32'h0, 3, 5, 1, 16'hFFFF, 0, 0, 0);
`endif

    // stop during a stalled beat
    start_cfg(2'd0, 32'h0000_1234, 32'h0, 6, 20, 0, 16'h0, 1, 1);
    tready = 1'b1;
    wait_valid(1'b1, "stop_first_valid");
    @(negedge clk);
    tready = 1'b0;
    @(negedge clk);
    check("stall_hold", tdata, model_beat(1));
    stop_i = 1'b1;
    #1;
    check("stop_tlast_forced", tlast, 1);
    check("stop_data_unchanged", tdata, model_beat(1));
    @(negedge clk);
    stop_i = 1'b0;
    #1;
    check("stop_pending_valid", tvalid, 1);
    check("stop_pending_tlast", tlast, 1);
    check("stop_pending_data", tdata, model_beat(1));
    check("stop_pending_busy", busy_o, 1);
    tready = 1'b1;
    @(negedge clk);
    check("stop_idle_tvalid", tvalid, 0);
    check("stop_idle_busy", busy_o, 0);
    check("stop_idle_dds_en", dds_en_o, 0);
    seen = 0;
    repeat (25) begin @(negedge clk); if (tvalid) seen = 1; end
    check("no_valid_after_stop", seen, 0);

    // stop in the inter-pulse gap
    start_cfg(2'd0, 32'h0000_0777, 32'h0, 2, 20, 0, 16'h0, 1, 1);
    wait_valid(1'b1, "gap_first_valid");
    wait_valid(1'b0, "gap_reached");
    check("gap_busy", busy_o, 1);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("gap_stop_busy", busy_o, 0);
    check("gap_stop_dds_en", dds_en_o, 0);
    seen = 0;
    repeat (25) begin @(negedge clk); if (tvalid) seen = 1; end
    check("no_valid_after_gap_stop", seen, 0);

    // asynchronous reset mid-pulse
    start_cfg(2'd1, 32'h1000_0000, 32'h100, 8, 20, 0, 16'h0, 1, 1);
    wait_valid(1'b1, "areset_first_valid");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_tvalid", tvalid, 0);
    check("areset_dds_en", dds_en_o, 0);
    check("areset_busy", busy_o, 0);
    check("areset_tdata", tdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("areset_stays_idle", tvalid, 0);

    for (int k = 0; k < 8; k++) begin
      run_burst(2'($urandom), $urandom, $urandom, $urandom_range(1, 6), $urandom_range(1, 10),
                $urandom_range(1, 3), 16'($urandom), $urandom_range(1, 16), $urandom_range(1, 3), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
